// File: rtl/shift_request_arbiter_if.sv
// ============================================================================
// Module      : shift_request_arbiter_if
// Description : Request, shifter and response bundle for shift_request_arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface shift_request_arbiter_if #(
    parameter int N_REQ = 4
);
    localparam int ID_W = $clog2(N_REQ);

    logic [N_REQ-1:0]    i_req_valid;
    logic [N_REQ-1:0]    o_req_ready;
    logic [32*N_REQ-1:0] i_req_data;
    logic [5*N_REQ-1:0]  i_req_amt;
    logic [N_REQ-1:0]    i_req_signed;
    logic [N_REQ-1:0]    i_req_left;

    logic [31:0]         o_sh_data;
    logic [4:0]          o_sh_amt;
    logic                o_sh_signed;
    logic                o_sh_left;
    logic [31:0]         i_sh_result;

    logic                o_rsp_valid;
    logic [ID_W-1:0]     o_rsp_id;
    logic [31:0]         o_rsp_data;
    logic                i_rsp_ready;

    // Arbiter side
    modport slave (
        input  i_req_valid, i_req_data, i_req_amt, i_req_signed, i_req_left,
        input  i_sh_result, i_rsp_ready,
        output o_req_ready, o_sh_data, o_sh_amt, o_sh_signed, o_sh_left,
        output o_rsp_valid, o_rsp_id, o_rsp_data
    );

    // Requesters, shifter and consumer side
    modport master (
        output i_req_valid, i_req_data, i_req_amt, i_req_signed, i_req_left,
        output i_sh_result, i_rsp_ready,
        input  o_req_ready, o_sh_data, o_sh_amt, o_sh_signed, o_sh_left,
        input  o_rsp_valid, o_rsp_id, o_rsp_data
    );
endinterface

`default_nettype wire

// File: rtl/shift_request_arbiter.sv
// ============================================================================
// Module      : shift_request_arbiter
// Description : Round-robin sharing of one registered 32-bit barrel shifter
//               with a 2-entry credit-controlled response FIFO.
//               Macro SHIFT_ARB_FIXED_PRIO_EN selects fixed lowest-index priority.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module shift_request_arbiter #(
    parameter int N_REQ = 4
) (
    input  logic i_clk,
    input  logic i_rst_n,
    shift_request_arbiter_if.slave bus
);
    localparam int ID_W = $clog2(N_REQ);

    logic              inflight_q, inflight_d;
    logic [ID_W-1:0]   inflight_id_q, inflight_id_d;
    logic              wr_ptr_q, wr_ptr_d;
    logic              rd_ptr_q, rd_ptr_d;
    logic [1:0]        occ_q, occ_d;
    logic [31:0]       mem_data_q [2];
    logic [31:0]       mem_data_d [2];
    logic [ID_W-1:0]   mem_id_q [2];
    logic [ID_W-1:0]   mem_id_d [2];
`ifndef SHIFT_ARB_FIXED_PRIO_EN
    logic [ID_W-1:0]   rr_ptr_q, rr_ptr_d;
`endif

    logic              w_pop;
    logic              w_push;
    logic [2:0]        w_outstanding;
    logic              w_issue_ok;
    logic              w_grant_found;
    logic              w_grant_vld;
    logic [ID_W-1:0]   w_grant_idx;

`ifndef SHIFT_ARB_FIXED_PRIO_EN
    function automatic logic [ID_W-1:0] rr_idx(input logic [ID_W-1:0] base, input int off);
        int s;
        s = int'(base) + off;
        if (s >= N_REQ) s = s - N_REQ;
        return ID_W'(s);
    endfunction
`endif

    assign w_pop         = bus.o_rsp_valid && bus.i_rsp_ready;
    assign w_push        = inflight_q;
    // Credit: FIFO entries plus the in-flight result must leave room for one more.
    assign w_outstanding = 3'(occ_q) + 3'(inflight_q) - 3'(w_pop);
    assign w_issue_ok    = w_outstanding < 3'd2;

    always_comb begin
        w_grant_found = 1'b0;
        w_grant_idx   = '0;
`ifdef SHIFT_ARB_FIXED_PRIO_EN
        for (int i = N_REQ - 1; i >= 0; i--) begin
            if (bus.i_req_valid[i]) begin
                w_grant_found = 1'b1;
                w_grant_idx   = ID_W'(i);
            end
        end
`else
        for (int i = 0; i < N_REQ; i++) begin
            if (!w_grant_found && bus.i_req_valid[rr_idx(rr_ptr_q, i)]) begin
                w_grant_found = 1'b1;
                w_grant_idx   = rr_idx(rr_ptr_q, i);
            end
        end
`endif
        w_grant_vld = w_grant_found && w_issue_ok && i_rst_n;
    end

    always_comb begin
        bus.o_req_ready = '0;
        bus.o_sh_data   = '0;
        bus.o_sh_amt    = '0;
        bus.o_sh_signed = 1'b0;
        bus.o_sh_left   = 1'b0;
        if (w_grant_vld) begin
            bus.o_req_ready[w_grant_idx] = 1'b1;
            bus.o_sh_data   = bus.i_req_data[32*int'(w_grant_idx) +: 32];
            bus.o_sh_amt    = bus.i_req_amt[5*int'(w_grant_idx) +: 5];
            bus.o_sh_signed = bus.i_req_signed[w_grant_idx];
            bus.o_sh_left   = bus.i_req_left[w_grant_idx];
        end
    end

    always_comb begin
        inflight_d    = w_grant_vld;
        inflight_id_d = w_grant_vld ? w_grant_idx : inflight_id_q;
`ifndef SHIFT_ARB_FIXED_PRIO_EN
        rr_ptr_d      = w_grant_vld ? rr_idx(w_grant_idx, 1) : rr_ptr_q;
`endif
        occ_d         = occ_q + 2'(w_push) - 2'(w_pop);
        wr_ptr_d      = wr_ptr_q ^ w_push;
        rd_ptr_d      = rd_ptr_q ^ w_pop;
        mem_data_d    = mem_data_q;
        mem_id_d      = mem_id_q;
        if (w_push) begin
            mem_data_d[wr_ptr_q] = bus.i_sh_result;
            mem_id_d[wr_ptr_q]   = inflight_id_q;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            inflight_q    <= 1'b0;
            inflight_id_q <= '0;
            wr_ptr_q      <= 1'b0;
            rd_ptr_q      <= 1'b0;
            occ_q         <= '0;
            for (int i = 0; i < 2; i++) begin
                mem_data_q[i] <= '0;
                mem_id_q[i]   <= '0;
            end
`ifndef SHIFT_ARB_FIXED_PRIO_EN
            rr_ptr_q      <= '0;
`endif
        end else begin
            inflight_q    <= inflight_d;
            inflight_id_q <= inflight_id_d;
            wr_ptr_q      <= wr_ptr_d;
            rd_ptr_q      <= rd_ptr_d;
            occ_q         <= occ_d;
            mem_data_q    <= mem_data_d;
            mem_id_q      <= mem_id_d;
`ifndef SHIFT_ARB_FIXED_PRIO_EN
            rr_ptr_q      <= rr_ptr_d;
`endif
        end
    end

    assign bus.o_rsp_valid = (occ_q != 2'd0);
    assign bus.o_rsp_id    = mem_id_q[rd_ptr_q];
    assign bus.o_rsp_data  = mem_data_q[rd_ptr_q];

    a_fifo_no_overflow: assert property (@(posedge i_clk) disable iff (!i_rst_n)
        !(w_push && !w_pop && (occ_q == 2'd2)));

endmodule

`default_nettype wire

// File: tb/tb_shift_request_arbiter.sv
// ============================================================================
// Module      : tb_shift_request_arbiter
// Description : Scoreboard bench for shift_request_arbiter with a shifter model.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_shift_request_arbiter;
    localparam int N_REQ = 4;

    logic clk = 1'b0;
    logic rst_n = 1'b1;
    always #5 clk = ~clk;

    shift_request_arbiter_if #(.N_REQ(N_REQ)) bus ();

    shift_request_arbiter #(.N_REQ(N_REQ)) dut (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .bus     (bus)
    );

    typedef struct {
        logic [2:0]  id;
        logic [31:0] data;
    } exp_t;

    exp_t sb_q[$];
    int   checks = 0;
    int   failures = 0;
    int   last_grant;
    bit   popped;

    function automatic logic [31:0] shift_ref(input logic [31:0] d, input logic [4:0] a,
                                              input logic s, input logic l);
        if (l) return d << a;
        else if (s) return 32'($signed(d) >>> a);
        else return d >> a;
    endfunction

    // Registered shifter shared by all requesters
    always @(posedge clk)
        bus.i_sh_result <= shift_ref(bus.o_sh_data, bus.o_sh_amt, bus.o_sh_signed, bus.o_sh_left);

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic set_req(input int k, input bit v, input logic [31:0] d,
                           input logic [4:0] a, input bit s, input bit l);
        bus.i_req_valid[k]       = v;
        bus.i_req_data[32*k +: 32] = d;
        bus.i_req_amt[5*k +: 5]  = a;
        bus.i_req_signed[k]      = s;
        bus.i_req_left[k]        = l;
    endtask

    // One clock: observe handshakes just after inputs settle, then advance to next negedge.
    task automatic cyc();
        exp_t e;
        #1;
        last_grant = -1;
        popped     = 1'b0;
        check_eq("ready_onehot", 64'($countones(bus.o_req_ready) <= 1), 64'd1);
        for (int k = 0; k < N_REQ; k++) begin
            if (bus.i_req_valid[k] && bus.o_req_ready[k]) begin
                last_grant = k;
                e.id   = 3'(k);
                e.data = shift_ref(bus.i_req_data[32*k +: 32], bus.i_req_amt[5*k +: 5],
                                   bus.i_req_signed[k], bus.i_req_left[k]);
                check_eq("sh_data", 64'(bus.o_sh_data), 64'(bus.i_req_data[32*k +: 32]));
                sb_q.push_back(e);
            end
        end
        if (last_grant < 0)
            check_eq("sh_idle", 64'({bus.o_sh_data, bus.o_sh_amt, bus.o_sh_signed, bus.o_sh_left}), 64'd0);
        if (bus.o_rsp_valid && bus.i_rsp_ready) begin
            popped = 1'b1;
            check_eq("rsp_expected", 64'(sb_q.size() != 0), 64'd1);
            if (sb_q.size() != 0) begin
                e = sb_q.pop_front();
                check_eq("rsp_id", 64'(bus.o_rsp_id), 64'(e.id));
                check_eq("rsp_data", 64'(bus.o_rsp_data), 64'(e.data));
            end
        end
        @(negedge clk);
    endtask

    task automatic drain();
        bus.i_req_valid = '0;
        bus.i_rsp_ready = 1'b1;
        for (int i = 0; i < 8 && sb_q.size() != 0; i++) cyc();
        check_eq("drain_empty", 64'(sb_q.size()), 64'd0);
        cyc();
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        sb_q.delete();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    initial begin
        int   grants;
        logic [31:0] head;

        bus.i_req_valid  = '0;
        bus.i_req_data   = '0;
        bus.i_req_amt    = '0;
        bus.i_req_signed = '0;
        bus.i_req_left   = '0;
        bus.i_rsp_ready  = 1'b1;
        #2 rst_n = 1'b0;
        @(negedge clk);

        // Reset state, with requests pending
        bus.i_req_valid = '1;
        #1;
        check_eq("rst_rsp_valid", 64'(bus.o_rsp_valid), 64'd0);
        check_eq("rst_rsp_id",    64'(bus.o_rsp_id),    64'd0);
        check_eq("rst_rsp_data",  64'(bus.o_rsp_data),  64'd0);
        check_eq("rst_req_ready", 64'(bus.o_req_ready), 64'd0);
        check_eq("rst_sh", 64'({bus.o_sh_data, bus.o_sh_amt, bus.o_sh_signed, bus.o_sh_left}), 64'd0);
        bus.i_req_valid = '0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // Single arithmetic right shift, 2-cycle latency
        set_req(0, 1, 32'h8000_0000, 5'd4, 1, 0);
        cyc();
        check_eq("t1_grant", 64'(last_grant), 64'd0);
        bus.i_req_valid = '0;
        #1 check_eq("t1_lat_t1", 64'(bus.o_rsp_valid), 64'd0);
        cyc();
        #1;
        check_eq("t1_lat_t2", 64'(bus.o_rsp_valid), 64'd1);
        check_eq("t1_id",     64'(bus.o_rsp_id),    64'd0);
        check_eq("t1_data",   64'(bus.o_rsp_data),  64'hF800_0000);
        cyc();
        drain();

        // Left then logical right on requester 1, back to back
        set_req(1, 1, 32'h0000_0001, 5'd31, 0, 1);
        cyc();
        check_eq("t2_grant_a", 64'(last_grant), 64'd1);
        set_req(1, 1, 32'hF000_0000, 5'd8, 0, 0);
        cyc();
        check_eq("t2_grant_b", 64'(last_grant), 64'd1);
        bus.i_req_valid = '0;
        #1;
        check_eq("t2_id_a",   64'(bus.o_rsp_id),   64'd1);
        check_eq("t2_data_a", 64'(bus.o_rsp_data), 64'h8000_0000);
        cyc();
        #1 check_eq("t2_data_b", 64'(bus.o_rsp_data), 64'h00F0_0000);
        drain();

        // Round-robin fairness with every requester valid
        do_reset();
        for (int k = 0; k < N_REQ; k++)
            set_req(k, 1, 32'h9234_5678 + 32'(k * 32'h1111), 5'(k + 1), k[0], k == 3);
        for (int i = 0; i < 6; i++) begin
            cyc();
            check_eq("rr_grant", 64'(last_grant), 64'(i % N_REQ));
            if (i >= 2) check_eq("rr_b2b_rsp", 64'(popped), 64'd1);
        end
        bus.i_req_valid = '0;
        for (int i = 0; i < 2; i++) begin
            cyc();
            check_eq("rr_tail_rsp", 64'(popped), 64'd1);
        end
        drain();

        // Back-pressure: two outstanding, then stall with a stable head
        bus.i_rsp_ready = 1'b0;
        bus.i_req_valid = '1;
        grants = 0;
        for (int i = 0; i < 4; i++) begin
            cyc();
            if (last_grant >= 0) grants++;
        end
        #1 head = bus.o_rsp_data;
        for (int i = 0; i < 3; i++) begin
            cyc();
            if (last_grant >= 0) grants++;
            #1;
            check_eq("bp_valid", 64'(bus.o_rsp_valid), 64'd1);
            check_eq("bp_head_stable", 64'(bus.o_rsp_data), 64'(head));
        end
        check_eq("bp_grants", 64'(grants), 64'd2);
        bus.i_rsp_ready = 1'b1;
        cyc();
        check_eq("bp_pop", 64'(popped), 64'd1);
        check_eq("bp_third_grant", 64'(last_grant >= 0), 64'd1);
        drain();

        // Reset while the FIFO and the shifter both hold results
        bus.i_rsp_ready = 1'b0;
        bus.i_req_valid = 4'b0001;
        cyc();
        cyc();
        bus.i_req_valid = '0;
        cyc();
        rst_n = 1'b0;
        sb_q.delete();
        #1 check_eq("mid_rst_valid", 64'(bus.o_rsp_valid), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        bus.i_rsp_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            cyc();
            check_eq("no_stale_rsp", 64'(bus.o_rsp_valid), 64'd0);
        end
        bus.i_req_valid = '1;
        cyc();
        check_eq("post_rst_grant", 64'(last_grant), 64'd0);
        drain();

        // Requesters 0 and 2 contending
        bus.i_req_valid = 4'b0101;
        for (int i = 0; i < 6; i++) begin
            cyc();
`ifdef SHIFT_ARB_FIXED_PRIO_EN
            check_eq("fixed_grant", 64'(last_grant), 64'd0);
`else
            check_eq("rr02_grant", 64'(last_grant), (i % 2 == 0) ? 64'd2 : 64'd0);
`endif
        end
        drain();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #50000;
        failures++;
        $display("FAIL timeout: got no finish expected finish");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $fatal(1, "timeout");
    end
endmodule

`default_nettype wire

// File: doc/shift_request_arbiter.md
Name: shift_request_arbiter

Overview:
- Shares one 32-bit registered barrel shifter between N_REQ requesters, each with a valid/ready request port.
- Round-robin arbitration picks at most one request per cycle and drives it onto the shifter operand bus.
- Tracks the single-cycle shifter latency and the requester id of each issued operation.
- Buffers results in a 2-entry response FIFO with valid/ready back-pressure, so full throughput is sustained when the consumer is always ready.

Parameters:
- N_REQ, 4, number of requesters (2..8).
- ID_W, $clog2(N_REQ), width of the requester id on the response port (derived, not overridden).

Ports:
- i_clk  in  1  clock; all state updates on its rising edge.
- i_rst_n  in  1  asynchronous, active-low reset.
- i_req_valid  in  N_REQ  request valid, one bit per requester.
- o_req_ready  out  N_REQ  request accepted this cycle, one-hot or zero.
- i_req_data  in  32*N_REQ  operand; requester k occupies bits [32k+31:32k].
- i_req_amt  in  5*N_REQ  shift amount per requester.
- i_req_signed  in  N_REQ  arithmetic right shift per requester.
- i_req_left  in  N_REQ  left shift per requester; takes precedence over signed.
- o_sh_data  out  32  shifter operand.
- o_sh_amt  out  5  shifter shift amount.
- o_sh_signed  out  1  shifter signed select.
- o_sh_left  out  1  shifter left select.
- i_sh_result  in  32  shifter output; valid one cycle after the operand is driven.
- o_rsp_valid  out  1  response FIFO head is valid.
- o_rsp_id  out  ID_W  requester index of the head result.
- o_rsp_data  out  32  head result.
- i_rsp_ready  in  1  consumer accepts the head result.

Behaviour:
- Reset (async assert, sync release):
  - in-flight flag, in-flight id, FIFO pointers and occupancy, and round-robin pointer all clear to 0.
  - o_rsp_valid=0, o_rsp_id=0, o_rsp_data=0.
  - Combinationally, o_req_ready=0 and o_sh_* = 0 while reset is asserted.
- pop = o_rsp_valid && i_rsp_ready.
- issue_ok = (occ + inflight - pop) < 2, where occ is 0..2.
- Grant:
  - If issue_ok, the first requester with valid=1 searching from rr_ptr upward (modulo N_REQ) is granted.
  - o_req_ready[g]=1 in the same cycle; this is combinational from valid and state. Handshake = valid && ready.
- Shifter operands:
  - On a grant, o_sh_* equal the granted requester's fields.
  - With no grant, o_sh_* = 0.
  - The shifter registers its inputs, so the result appears on i_sh_result in the next cycle.
- On a grant:
  - inflight <= 1.
  - inflight_id <= g.
  - rr_ptr <= (g+1) mod N_REQ.
- With no grant: inflight <= 0 and rr_ptr is unchanged.
- When inflight=1, i_sh_result and inflight_id are pushed into the FIFO at that edge.
  - The credit rule guarantees the push never overflows; overflow is a design error and is asserted against.
- Same-cycle push and pop are allowed; occ is unchanged in that case.
- FIFO read pointer and write pointer are 1 bit each and wrap 1→0.
- o_rsp_* are driven from the FIFO head, registered storage.
- When o_rsp_valid=1 and i_rsp_ready=0, o_rsp_id and o_rsp_data are held stable.
- Throughput:
  - With i_rsp_ready=1 continuously, one issue per cycle.
  - Issue-to-o_rsp_valid latency is 2 cycles: issue at t, result on i_sh_result at t+1, head valid at t+2.
- With i_rsp_ready=0, at most 2 results are outstanding in total (FIFO plus in-flight); further requests are stalled.
- A requester that deasserts valid before the handshake loses nothing, because no state is kept per request.
- Reset asserted mid-operation discards both the in-flight result and the FIFO contents.

Optional Feature:
- Macro: SHIFT_ARB_FIXED_PRIO_EN.
- Defined: fixed priority; the lowest-index valid requester always wins, and rr_ptr is removed.
- Undefined: round-robin as specified above.
- All other behaviour is identical in both builds.

Test Plan:
- Single request: req0 valid, data=0x8000_0000, amt=4, signed=1, left=0, i_rsp_ready=1.
  - o_req_ready[0]=1 in cycle t.
  - o_rsp_valid=1 at t+2 with id=0, data=0xF800_0000.
- Left and logical shifts: req1 data=0x0000_0001, amt=31, left=1 → rsp id=1, data=0x8000_0000. Then data=0xF000_0000, amt=8, unsigned right → data=0x00F0_0000.
- Round-robin fairness: all 4 requesters held valid, i_rsp_ready=1.
  - Grants in order 0,1,2,3,0,1.
  - Responses arrive back-to-back with ids in the same order, one per cycle.
- Back-pressure: all requesters valid, i_rsp_ready=0.
  - Exactly 2 grants occur, then o_req_ready=0 continuously.
  - Head data stays stable.
  - After raising i_rsp_ready, the third grant occurs in the same cycle as the first pop.
- Reset mid-flight: assert i_rst_n=0 the cycle after a grant.
  - o_rsp_valid=0 immediately.
  - After release, no stale response appears and the first new grant goes to req0.
- SHIFT_ARB_FIXED_PRIO_EN build: req0 and req2 held valid → req0 is granted every cycle and req2 is never granted.
